mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum number of REQ-state cycles allowed without mem_ack (range 1..255).
REQ-002 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-004 ctrl_mem_read_ex_mem  in  1  SHALL be the load request from EX/MEM.
REQ-005 ctrl_mem_write_ex_mem  in  1  SHALL be the store request from EX/MEM.
REQ-006 alu_main_out_ex_mem  in  32  SHALL be the byte address.
REQ-007 reg_2_content_ex_mem  in  32  SHALL be the store data.
REQ-008 mem_req  out  1  SHALL be the request to data memory.
REQ-009 mem_we  out  1  SHALL be high for a write, low for a read.
REQ-010 mem_addr  out  32  SHALL be the memory address.
REQ-011 mem_wdata  out  32  SHALL be the memory write data.
REQ-012 mem_ack  in  1  SHALL be the completion strobe from memory.
REQ-013 mem_rdata  in  32  SHALL be the read data, valid when mem_ack=1.
REQ-014 data_mem_out  out  32  SHALL be the load result to MEM/WB.
REQ-015 stall_mem  out  1  SHALL freeze PC, IF/ID, ID/EX and EX/MEM while high.
REQ-016 mem_error  out  1  SHALL be a sticky error flag.
REQ-017 mem_error_code  out  2  SHALL report the first error: 01 misaligned, 10 timeout, 11 read+write both set.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, DONE.
REQ-019 IDLE with rd|wr and no error condition -> REQ; latch mem_addr, mem_wdata and mem_we (=wr) on that edge.
REQ-020 IDLE with rd|wr and an error condition -> DONE directly; mem_req is never asserted.
REQ-021 Error conditions: address[1:0]!=0 gives code 01; rd&wr gives code 11; if both apply, code 11 wins.
REQ-022 stall_mem SHALL be combinational: high when (IDLE and (rd|wr)) or state is REQ; low in DONE.
REQ-023 mem_req SHALL be registered: high exactly while in REQ.
REQ-024 mem_addr, mem_wdata and mem_we SHALL stay stable throughout REQ.
REQ-025 REQ with mem_ack=1 -> DONE; on a read, data_mem_out <= mem_rdata on the same edge.
REQ-026 data_mem_out SHALL hold its value otherwise, including through writes and errors.
REQ-027 The 8-bit timeout counter SHALL clear on REQ entry and increment each REQ cycle without ack.
REQ-028 Timeout: in a REQ cycle where the counter equals TIMEOUT_CYCLES-1 and mem_ack=0 -> DONE with code 10; a read sets data_mem_out <= 0.
REQ-029 When both apply in the same cycle, mem_ack SHALL win over timeout.
REQ-030 DONE SHALL last exactly one cycle and then go to IDLE unconditionally. DONE has stall_mem low, so EX/MEM advances and the same access is never reissued.
REQ-031 mem_ack outside REQ SHALL be ignored.
REQ-032 mem_error and mem_error_code SHALL latch on the first error only; later errors leave them unchanged.
REQ-033 Minimum load latency: IDLE detect (stall), REQ with ack (stall), DONE (data valid) gives 2 stall cycles.

Reset
REQ-034 reset=1 SHALL force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_mem_out=0, mem_error=0, mem_error_code=00, counter=0.
REQ-035 Reset during REQ SHALL drop mem_req on that edge; the pending access is abandoned and any later mem_ack is ignored.
REQ-036 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Load at address 0x100, mem_ack on the 1st REQ cycle with mem_rdata=0xDEADBEEF -> stall_mem high for 2 cycles; data_mem_out=0xDEADBEEF in DONE; mem_req high for 1 cycle.
REQ-038 Store at address 0x104 with data 0x12345678, ack after 3 REQ cycles -> mem_we=1, address and data stable for 3 cycles; data_mem_out unchanged; 4 stall cycles.
REQ-039 Load at address 0x102 -> no mem_req; one stall cycle, then DONE; mem_error=1 with code 01.
REQ-040 TIMEOUT_CYCLES=15, load, never acked -> mem_req high for exactly 15 cycles; code 10; data_mem_out=0; next access still served.
REQ-041 rd=wr=1 at address 0x200 -> code 11, no request; a following misaligned access leaves the code at 11.
REQ-042 reset asserted in the 2nd REQ cycle, then mem_ack one cycle later -> IDLE, all outputs at reset values, and the ack is ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer for the MEM stage: turns EX/MEM load/store
// requests into a req/ack memory transaction, stalls the pipeline meanwhile and flags errors.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mem_read_ex_mem,
    input  logic        ctrl_mem_write_ex_mem,
    input  logic [31:0] alu_main_out_ex_mem,
    input  logic [31:0] reg_2_content_ex_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data_mem_out,
    output logic        stall_mem,
    output logic        mem_error,
    output logic [1:0]  mem_error_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] timeout_cnt;
    logic       access;
    logic [1:0] req_err_code;

    assign access = ctrl_mem_read_ex_mem | ctrl_mem_write_ex_mem;

    // Read+write together outranks misalignment when both apply.
    always_comb begin
        req_err_code = 2'b00;
        if (ctrl_mem_read_ex_mem && ctrl_mem_write_ex_mem)
            req_err_code = 2'b11;
        else if (alu_main_out_ex_mem[1:0] != 2'b00)
            req_err_code = 2'b01;
    end

    assign stall_mem = ((state == IDLE) && access) || (state == REQ);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            timeout_cnt    <= 8'd0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_wdata      <= 32'd0;
            data_mem_out   <= 32'd0;
            mem_error      <= 1'b0;
            mem_error_code <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (req_err_code != 2'b00) begin
                            state <= DONE;
                            if (!mem_error) begin
                                mem_error      <= 1'b1;
                                mem_error_code <= req_err_code;
                            end
                        end else begin
                            state       <= REQ;
                            mem_req     <= 1'b1;
                            mem_we      <= ctrl_mem_write_ex_mem;
                            mem_addr    <= alu_main_out_ex_mem;
                            mem_wdata   <= reg_2_content_ex_mem;
                            timeout_cnt <= 8'd0;
                        end
                    end
                end
                REQ: begin
                    // An ack arriving on the last allowed cycle still completes the access.
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we)
                            data_mem_out <= mem_rdata;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we)
                            data_mem_out <= 32'd0;
                        if (!mem_error) begin
                            mem_error      <= 1'b1;
                            mem_error_code <= 2'b10;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
